// File: rtl/alu_operand_stage.sv
// LC2K ID/EX operand stage: forwards, selects and registers ALU operands A/B plus store/compare data.
// One-cycle latency; load-use hazards and a held output both deassert in_ready, flush always consumes.
module alu_operand_stage #(
    parameter int DATA_W     = 32,
    parameter int OFFSET_W   = 16,
    parameter int REG_ADDR_W = 3,
    parameter int NUM_FWD    = 2,
    parameter int REG0_ZERO  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [REG_ADDR_W-1:0]          in_regA_addr,
    input  logic [REG_ADDR_W-1:0]          in_regB_addr,
    input  logic [DATA_W-1:0]              in_regA_value,
    input  logic [DATA_W-1:0]              in_regB_value,
    input  logic [OFFSET_W-1:0]            in_offset,
    input  logic                           in_valb_sel,
    input  logic                           in_useA,
    input  logic                           in_useB,
    input  logic [NUM_FWD-1:0]             fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0]  fwd_dest,
    input  logic [NUM_FWD*DATA_W-1:0]      fwd_data,
    input  logic [NUM_FWD-1:0]             fwd_pending,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_alu_a,
    output logic [DATA_W-1:0]              out_alu_b,
    output logic [DATA_W-1:0]              out_regB,
    output logic [CNT_W-1:0]               stall_count
);

    localparam int EXT_W = DATA_W - OFFSET_W;

    typedef struct packed {
        logic              hit;
        logic              pend;
        logic [DATA_W-1:0] value;
    } fwdRes_t;

    // Lowest index wins, so a younger non-pending producer shadows an older pending one.
    function automatic fwdRes_t lookup(
        input logic [REG_ADDR_W-1:0]         addr,
        input logic [DATA_W-1:0]             regVal,
        input logic [NUM_FWD-1:0]            fv,
        input logic [NUM_FWD*REG_ADDR_W-1:0] fd,
        input logic [NUM_FWD*DATA_W-1:0]     fdat,
        input logic [NUM_FWD-1:0]            fp
    );
        fwdRes_t res;
        logic [DATA_W-1:0] hitData;
        res.hit  = 1'b0;
        res.pend = 1'b0;
        hitData  = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fv[i] && (fd[i*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
                res.hit  = 1'b1;
                res.pend = fp[i];
                hitData  = fdat[i*DATA_W +: DATA_W];
            end
        end
        if ((REG0_ZERO != 0) && (addr == '0)) begin
            res.hit   = 1'b0;
            res.pend  = 1'b0;
            res.value = '0;
        end else begin
            res.value = (res.hit && !res.pend) ? hitData : regVal;
        end
        return res;
    endfunction

    fwdRes_t           resA;
    fwdRes_t           resB;
    logic [DATA_W-1:0] extOffset;
    logic              hazard;
    logic              capture;

    always_comb begin
        resA = lookup(in_regA_addr, in_regA_value, fwd_valid, fwd_dest, fwd_data, fwd_pending);
        resB = lookup(in_regB_addr, in_regB_value, fwd_valid, fwd_dest, fwd_data, fwd_pending);
    end

    assign extOffset = {{EXT_W{in_offset[OFFSET_W-1]}}, in_offset};

    assign hazard = in_valid & ((in_useA & resA.hit & resA.pend) |
                                (in_useB & resB.hit & resB.pend));

    // Reset forces ready high so upstream never sees a stall while the stage is cleared.
    assign in_ready = !rst_n | flush | (!hazard & (!out_valid | out_ready));
    assign capture  = in_valid & in_ready & !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_alu_a <= '0;
            out_alu_b <= '0;
            out_regB  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_alu_a <= resA.value;
            out_alu_b <= in_valb_sel ? resB.value : extOffset;
            out_regB  <= resB.value;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (hazard && !flush && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: expected operands are queued at issue and popped by a monitor.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_regA_addr, in_regB_addr;
    logic [31:0] in_regA_value, in_regB_value;
    logic [15:0] in_offset;
    logic        in_valb_sel, in_useA, in_useB;
    logic [1:0]  fwd_valid, fwd_pending;
    logic [5:0]  fwd_dest;
    logic [63:0] fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] out_alu_a, out_alu_b, out_regB;
    logic [3:0]  stall_count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rb;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    alu_operand_stage #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regA_addr(in_regA_addr), .in_regB_addr(in_regB_addr),
        .in_regA_value(in_regA_value), .in_regB_value(in_regB_value),
        .in_offset(in_offset), .in_valb_sel(in_valb_sel),
        .in_useA(in_useA), .in_useB(in_useB),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .fwd_pending(fwd_pending),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_regB(out_regB),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: a=%0h b=%0h regB=%0h with empty queue", out_alu_a, out_alu_b, out_regB);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check("sb_alu_a", out_alu_a, e.a);
                check("sb_alu_b", out_alu_b, e.b);
                check("sb_regB", out_regB, e.rb);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic [2:0] aAddr, input logic [2:0] bAddr,
                         input logic [31:0] aVal, input logic [31:0] bVal,
                         input logic [15:0] off, input logic valbSel);
        in_regA_addr  = aAddr;
        in_regB_addr  = bAddr;
        in_regA_value = aVal;
        in_regB_value = bVal;
        in_offset     = off;
        in_valb_sel   = valbSel;
        in_useA       = 1'b1;
        in_useB       = 1'b1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] rb);
        exp_t e;
        e.a = a; e.b = b; e.rb = rb;
        expQ.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        setIn(3'd0, 3'd0, 32'd0, 32'd0, 16'd0, 1'b0);
        fwd_valid = '0; fwd_pending = '0; fwd_dest = '0; fwd_data = '0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_a", out_alu_a, 32'd0);
        check("rst_alu_b", out_alu_b, 32'd0);
        check("rst_regB", out_regB, 32'd0);
        check("rst_stall", {28'd0, stall_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #6 rst_n = 1'b1;
        step();

        // Basic operand select: offset then regB as operand B.
        setIn(3'd1, 3'd2, 32'd5, 32'd7, 16'hFFFE, 1'b0);
        in_valid = 1'b1;
        push(32'd5, 32'hFFFFFFFE, 32'd7);
        step();
        check("basic_out_valid", {31'd0, out_valid}, 32'd1);
        in_valb_sel = 1'b1;
        push(32'd5, 32'd7, 32'd7);
        step();

        // Forwarding priority and register-0 suppression.
        fwd_valid = 2'b11; fwd_dest = {3'd3, 3'd3}; fwd_data = {32'd200, 32'd100};
        setIn(3'd3, 3'd5, 32'd9, 32'd55, 16'd1, 1'b0);
        push(32'd100, 32'd1, 32'd55);
        step();
        fwd_valid = 2'b10;
        push(32'd200, 32'd1, 32'd55);
        step();
        fwd_valid = 2'b01; fwd_dest = {3'd3, 3'd0};
        setIn(3'd0, 3'd5, 32'd9, 32'd55, 16'd1, 1'b0);
        push(32'd0, 32'd1, 32'd55);
        step();
        in_valid = 1'b0; fwd_valid = '0;
        step();

        // Load-use: three stall cycles, then the load result forwards.
        fwd_valid = 2'b01; fwd_dest = {3'd0, 3'd2}; fwd_pending = 2'b01; fwd_data = '0;
        setIn(3'd1, 3'd2, 32'd11, 32'd6, 16'd0, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lu_in_ready", {31'd0, in_ready}, 32'd0);
            check("lu_out_valid", {31'd0, out_valid}, 32'd0);
            step();
        end
        check("lu_stall_count", {28'd0, stall_count}, 32'd3);
        fwd_pending = 2'b00; fwd_data = {32'd0, 32'd42};
        #1;
        check("lu_release_ready", {31'd0, in_ready}, 32'd1);
        push(32'd11, 32'd42, 32'd42);
        step();
        check("lu_capture_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0; fwd_valid = '0;
        step();

        // Backpressure: outputs frozen while held, then back-to-back captures.
        setIn(3'd1, 3'd2, 32'd1, 32'd2, 16'd0, 1'b1);
        in_valid = 1'b1;
        push(32'd1, 32'd2, 32'd2);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setIn(3'd1, 3'd2, 32'd3 + 32'(i), 32'd4, 16'd0, 1'b1);
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_frozen_a", out_alu_a, 32'd1);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        setIn(3'd1, 3'd2, 32'd3, 32'd4, 16'd0, 1'b1);
        out_ready = 1'b1;
        push(32'd3, 32'd4, 32'd4);
        step();
        check("bp_b2b_valid", {31'd0, out_valid}, 32'd1);
        check("bp_b2b_a", out_alu_a, 32'd3);
        setIn(3'd1, 3'd2, 32'd5, 32'd6, 16'd0, 1'b1);
        push(32'd5, 32'd6, 32'd6);
        step();
        check("bp_b2b_a2", out_alu_a, 32'd5);
        in_valid = 1'b0;
        step();

        // Flush of a held instruction plus an incoming one: neither is ever presented.
        out_ready = 1'b0;
        setIn(3'd1, 3'd2, 32'hAA, 32'hBB, 16'd0, 1'b1);
        in_valid = 1'b1;
        step();
        check("fl_held_valid", {31'd0, out_valid}, 32'd1);
        setIn(3'd1, 3'd2, 32'hCC, 32'hDD, 16'd0, 1'b1);
        flush = 1'b1;
        #1;
        check("fl_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step();
        step();

        // Flush concurrent with a hazard leaves the counter alone.
        fwd_valid = 2'b01; fwd_dest = {3'd0, 3'd2}; fwd_pending = 2'b01;
        setIn(3'd1, 3'd2, 32'd1, 32'd2, 16'd0, 1'b1);
        in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_hazard_stall", {28'd0, stall_count}, 32'd3);

        // Saturation: 20 more hazard cycles must stop at 15.
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("sat_stall", {28'd0, stall_count}, 32'd15);
        check("sat_in_ready", {31'd0, in_ready}, 32'd0);

        // Asynchronous reset while an output is held.
        fwd_valid = '0; fwd_pending = '0; out_ready = 1'b0;
        setIn(3'd1, 3'd2, 32'h77, 32'h88, 16'd0, 1'b1);
        step();
        in_valid = 1'b0;
        check("mr_held_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_stall", {28'd0, stall_count}, 32'd0);
        check("mr_alu_a", out_alu_a, 32'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Parametrised ID/EX operand stage for the LC2K pipeline. It selects and registers ALU operand A and operand B. Operand B is either the register-B value or the sign-extended offset. Both operands take forwarding from up to NUM_FWD younger pipeline stages. The block detects load-use hazards, applies valid/ready backpressure, supports flush, and counts hazard stall cycles. It sits between the decode/register-read stage and the ALU.

Parameters:
DATA_W, 32, datapath and operand width
OFFSET_W, 16, raw offset field width; sign-extended to DATA_W
REG_ADDR_W, 3, register address width
NUM_FWD, 2, number of forwarding sources; index 0 = youngest (highest priority)
REG0_ZERO, 1, if 1, address 0 is never forwarded and always reads 0
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of held and incoming instruction
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage accepts instruction this cycle
in_regA_addr  input  REG_ADDR_W  source A register
in_regB_addr  input  REG_ADDR_W  source B register
in_regA_value  input  DATA_W  register-file read A
in_regB_value  input  DATA_W  register-file read B
in_offset  input  OFFSET_W  raw offset field
in_valb_sel  input  1  1 = operand B from regB, 0 = sign-extended offset
in_useA  input  1  instruction reads regA
in_useB  input  1  instruction reads regB (ALU or store data)
fwd_valid  input  NUM_FWD  source i will write a register
fwd_dest  input  NUM_FWD*REG_ADDR_W  destination of source i; slice i = bits [i*REG_ADDR_W +: REG_ADDR_W]
fwd_data  input  NUM_FWD*DATA_W  result of source i, same slicing
fwd_pending  input  NUM_FWD  source i result not yet available (load in flight)
out_valid  output  1  registered operands valid
out_ready  input  1  ALU stage accepts
out_alu_a  output  DATA_W  operand A
out_alu_b  output  DATA_W  operand B
out_regB  output  DATA_W  forwarded regB value (store data / beq compare)
stall_count  output  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0; out_alu_a, out_alu_b, out_regB=0; stall_count=0. in_ready is combinational and evaluates to 1 during reset.
- Sign extension: ext = {{(DATA_W-OFFSET_W){in_offset[OFFSET_W-1]}}, in_offset}.
- Forwarding per operand X (A, B):
  - Matching entry = lowest index i with fwd_valid[i] and fwd_dest[i]==addrX.
  - If a match exists and its fwd_pending is 0, value = fwd_data[i]. Otherwise value = in_regX_value.
  - If REG0_ZERO=1 and addrX==0, value = 0 and the operand never matches.
- Hazard: hazard = in_valid & ((in_useA & A matches pending entry) | (in_useB & B matches pending entry)). Only the highest-priority match is considered. A younger non-pending match shadows an older pending one.
- in_ready = flush | (!hazard & (!out_valid | out_ready)). Combinational; no combinational path from out_ready to out_valid.
- Capture (1-cycle latency): on a clock edge with in_valid & in_ready & !flush:
  - out_valid <= 1
  - out_alu_a <= fwdA
  - out_alu_b <= in_valb_sel ? fwdB : ext
  - out_regB <= fwdB
- Drain: out_valid & out_ready and no capture -> out_valid <= 0 (bubble). Data registers hold their last value.
- Hold: out_valid & !out_ready -> all outputs stable, in_ready=0.
- Hazard with downstream free: no capture. out_valid drops to 0 on the next edge if it was accepted; a bubble is inserted.
- Flush dominates everything: on a clock edge with flush=1, out_valid <= 0 and the incoming instruction is discarded (consumed, in_ready=1). Data registers may hold. The stall counter does not increment on a flush cycle.
- stall_count increments by 1 on each edge where hazard & !flush. It saturates at all-ones and does not wrap. It is cleared only by reset.
- Reset asserted mid-hold: out_valid clears immediately; held data is lost.
- Simultaneous drain and capture in one cycle: the new instruction replaces the old one with no bubble, giving full throughput.

Test Plan:
- Basic select: regA=5, regB=7, offset=16'hFFFE, valb_sel=0, no forwarding, out_ready=1 -> next cycle out_alu_a=5, out_alu_b=32'hFFFFFFFE, out_regB=7, out_valid=1. With valb_sel=1 -> out_alu_b=7.
- Forward priority: fwd0 dest=3 data=100, fwd1 dest=3 data=200, both valid, regA addr 3 (file value 9) -> out_alu_a=100. With fwd0 invalid -> 200. regA addr 0 with fwd0 dest=0 -> 0.
- Load-use: fwd0 dest=2 pending=1, in_regB_addr=2, in_useB=1 for 3 cycles, then pending=0 with data=42 -> in_ready=0 and out_valid=0 for 3 cycles, stall_count=3, then capture with out_regB=42.
- Backpressure: capture, hold out_ready=0 for 4 cycles while new inputs change -> outputs frozen, in_ready=0. Release -> back-to-back captures with no bubble.
- Flush: out_valid=1 held with out_ready=0, assert flush with in_valid=1 -> next cycle out_valid=0 and the incoming instruction is not presented. Flush concurrent with hazard -> stall_count unchanged.
- Reset/saturation: CNT_W=4, hold hazard 20 cycles -> stall_count=15. Pulse rst_n low mid-hold -> out_valid=0 and stall_count=0 asynchronously.
